// File: rtl/axim_ctrl_rd_burst_gen.sv
// AXI4 read-address burst generator: splits one (address, length) command into AR bursts
// with an outstanding-burst credit limit. Define AXIM_RD_4K_SPLIT_EN to split at 4 KB pages.
module axim_ctrl_rd_burst_gen #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_BURST_LEN       = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  input  logic                         m_axi_rlast
);

  localparam int unsigned Bpb  = C_DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(Bpb);
  localparam int unsigned OutW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0]              MaxOut    = OutW'(C_MAX_OUTSTANDING);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] BurstLenB = C_XFER_SIZE_WIDTH'(C_BURST_LEN);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0] rem_q, rem_d;
  logic [OutW-1:0]              out_q, out_d;
  logic                         done_q, done_d;

  logic       ar_hs;
  logic       r_last;
  logic [8:0] cur_beats;

`ifdef AXIM_RD_4K_SPLIT_EN
  logic [12:0] page_bytes;
  logic [12:0] page_beats;
  assign page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_beats = page_bytes >> OffW;
`endif

  // Beats in the burst currently presented on AR; stable while addr_q/rem_q are held.
  always_comb begin
    if (rem_q > BurstLenB) begin
      cur_beats = 9'(C_BURST_LEN);
    end else begin
      cur_beats = rem_q[8:0];
    end
`ifdef AXIM_RD_4K_SPLIT_EN
    if ({4'd0, cur_beats} > page_beats) begin
      cur_beats = page_beats[8:0];
    end
`endif
  end

  assign m_axi_arvalid = (state_q == StIssue) && (out_q < MaxOut);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = (state_q == StIssue) ? 8'(cur_beats - 9'd1) : 8'd0;
  assign ctrl_busy     = (state_q != StIdle);
  assign ctrl_done     = done_q;

  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_last = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  // Outstanding credit; rlast with nothing in flight saturates at zero.
  always_comb begin
    out_d = out_q;
    unique case ({ar_hs, r_last})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = (out_q != '0) ? out_q - OutW'(1) : '0;
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          if (ctrl_xfer_size_in_bytes == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = ctrl_addr_offset;
            rem_d   = ctrl_xfer_size_in_bytes >> OffW;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d = addr_q + (C_ADDR_WIDTH'(cur_beats) << OffW);
          rem_d  = rem_q - C_XFER_SIZE_WIDTH'(cur_beats);
          if (rem_d == '0) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_d == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axim_ctrl_rd_burst_gen.sv
// Directed bench for axim_ctrl_rd_burst_gen; expectations follow AXIM_RD_4K_SPLIT_EN if defined.
module tb_axim_ctrl_rd_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [63:0] addr;
  logic [31:0] size;
  logic        arready, rvalid, rready, rlast;

  logic        busy, done, arvalid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic        busy2, done2, arvalid2;
  logic [63:0] araddr2;
  logic [7:0]  arlen2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axim_ctrl_rd_burst_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (start),
    .ctrl_addr_offset        (addr),
    .ctrl_xfer_size_in_bytes (size),
    .ctrl_busy               (busy),
    .ctrl_done               (done),
    .m_axi_arvalid           (arvalid),
    .m_axi_arready           (arready),
    .m_axi_araddr            (araddr),
    .m_axi_arlen             (arlen),
    .m_axi_rvalid            (rvalid),
    .m_axi_rready            (rready),
    .m_axi_rlast             (rlast)
  );

  axim_ctrl_rd_burst_gen #(.C_MAX_OUTSTANDING(2)) dut2 (
    .clk                     (clk),
    .rst                     (rst),
    .ctrl_start              (start2),
    .ctrl_addr_offset        (addr),
    .ctrl_xfer_size_in_bytes (size),
    .ctrl_busy               (busy2),
    .ctrl_done               (done2),
    .m_axi_arvalid           (arvalid2),
    .m_axi_arready           (arready),
    .m_axi_araddr            (araddr2),
    .m_axi_arlen             (arlen2),
    .m_axi_rvalid            (rvalid),
    .m_axi_rready            (rready),
    .m_axi_rlast             (rlast)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rlast_beats(input int n);
    rvalid = 1'b1;
    rlast  = 1'b1;
    repeat (n) tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic go(input logic [63:0] a, input logic [31:0] s);
    addr  = a;
    size  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; addr = '0; size = '0;
    arready = 1'b0; rvalid = 1'b0; rready = 1'b1; rlast = 1'b0;
    tick(); tick();
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arlen", {56'd0, arlen}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick();

    // 8 KB from 0: two 64-beat bursts
    arready = 1'b1;
    go(64'h0, 32'd8192);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_arvalid0", {63'd0, arvalid}, 64'd1);
    chk("t1_araddr0", araddr, 64'h0);
    chk("t1_arlen0", {56'd0, arlen}, 64'd63);
    tick();
    chk("t1_arvalid1", {63'd0, arvalid}, 64'd1);
    chk("t1_araddr1", araddr, 64'h1000);
    chk("t1_arlen1", {56'd0, arlen}, 64'd63);
    tick();
    chk("t1_arvalid_drain", {63'd0, arvalid}, 64'd0);
    chk("t1_busy_drain", {63'd0, busy}, 64'd1);
    rlast_beats(1);
    chk("t1_done_early", {63'd0, done}, 64'd0);
    chk("t1_busy_mid", {63'd0, busy}, 64'd1);
    rlast_beats(1);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_busy_end", {63'd0, busy}, 64'd0);
    tick();
    chk("t1_done_pulse", {63'd0, done}, 64'd0);

    // 256 bytes from 0xF80 straddling a 4 KB page
    go(64'hF80, 32'd256);
    chk("t2_araddr0", araddr, 64'hF80);
`ifdef AXIM_RD_4K_SPLIT_EN
    chk("t2_arlen0", {56'd0, arlen}, 64'd1);
    tick();
    chk("t2_arvalid1", {63'd0, arvalid}, 64'd1);
    chk("t2_araddr1", araddr, 64'h1000);
    chk("t2_arlen1", {56'd0, arlen}, 64'd1);
    tick();
    chk("t2_arvalid_drain", {63'd0, arvalid}, 64'd0);
    rlast_beats(2);
`else
    chk("t2_arlen0", {56'd0, arlen}, 64'd3);
    tick();
    chk("t2_arvalid_drain", {63'd0, arvalid}, 64'd0);
    rlast_beats(1);
`endif
    chk("t2_done", {63'd0, done}, 64'd1);
    tick();

    // arready stall, start while busy ignored, handshake coincident with rlast
    arready = 1'b0;
    go(64'h2000, 32'd8192);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_arvalid", {63'd0, arvalid}, 64'd1);
      chk("t3_hold_araddr", araddr, 64'h2000);
      chk("t3_hold_arlen", {56'd0, arlen}, 64'd63);
      if (i == 2) begin
        addr  = 64'h9000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    arready = 1'b1;
    tick();
    chk("t3_araddr1", araddr, 64'h3000);
    chk("t3_arvalid1", {63'd0, arvalid}, 64'd1);
    rlast_beats(1);
    chk("t3_arvalid_drain", {63'd0, arvalid}, 64'd0);
    chk("t3_no_done_yet", {63'd0, done}, 64'd0);
    rlast_beats(1);
    chk("t3_done", {63'd0, done}, 64'd1);
    tick();

    // Zero-length command
    go(64'h5000, 32'd0);
    chk("t4_done", {63'd0, done}, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd0);
    chk("t4_arvalid", {63'd0, arvalid}, 64'd0);
    tick();
    chk("t4_done_pulse", {63'd0, done}, 64'd0);

    // Reset with three bursts outstanding, then a fresh transfer
    go(64'h0, 32'd20480);
    tick(); tick(); tick();
    chk("t5_arvalid_pre", {63'd0, arvalid}, 64'd1);
    chk("t5_araddr_pre", araddr, 64'h3000);
    arready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_done", {63'd0, done}, 64'd0);
    tick();
    chk("t5_no_done", {63'd0, done}, 64'd0);
    arready = 1'b1;
    go(64'h4000, 32'd4096);
    chk("t5_new_araddr", araddr, 64'h4000);
    chk("t5_new_arlen", {56'd0, arlen}, 64'd63);
    tick();
    rlast_beats(1);
    chk("t5_new_done", {63'd0, done}, 64'd1);
    tick();

    // Credit limit of 2 on the second instance
    addr = 64'h0; size = 32'd16384; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t6_arvalid0", {63'd0, arvalid2}, 64'd1);
    tick();
    chk("t6_araddr1", araddr2, 64'h1000);
    tick();
    chk("t6_credit_stall", {63'd0, arvalid2}, 64'd0);
    tick();
    chk("t6_still_stalled", {63'd0, arvalid2}, 64'd0);
    chk("t6_busy", {63'd0, busy2}, 64'd1);
    rlast_beats(1);
    chk("t6_arvalid_resume", {63'd0, arvalid2}, 64'd1);
    chk("t6_araddr2", araddr2, 64'h2000);
    tick();
    chk("t6_stall_again", {63'd0, arvalid2}, 64'd0);
    chk("t6_araddr3", araddr2, 64'h3000);
    rlast_beats(3);
    chk("t6_done", {63'd0, done2}, 64'd1);
    tick();
    chk("t6_idle", {63'd0, busy2}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axim_ctrl_rd_burst_gen.md
Name: axim_ctrl_rd_burst_gen

Overview:
Read-address burst generator for the AXI master control path.
- Takes one transfer command (byte address, byte length) and splits it into AXI4 read bursts.
- Issues the bursts on the AR channel and limits in-flight bursts using an internal outstanding-burst counter (incr on AR handshake, decr on R-channel rlast).
- Pulses done once every issued burst has returned its last beat.
- Sits upstream of the read data path; monitors the R channel and never drives it.

Parameters:
C_ADDR_WIDTH, 64, AXI address width.
C_DATA_WIDTH, 512, AXI data width in bits. Power of 2, ≥ 32. Bytes per beat: BPB = C_DATA_WIDTH/8.
C_XFER_SIZE_WIDTH, 32, width of the transfer-size field in bytes.
C_BURST_LEN, 64, maximum beats per burst. Power of 2, 1..256.
C_MAX_OUTSTANDING, 16, maximum bursts in flight, ≥ 1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
ctrl_start  in  1  start pulse; sampled only in IDLE.
ctrl_addr_offset  in  C_ADDR_WIDTH  start byte address, BPB-aligned.
ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  length in bytes, multiple of BPB.
ctrl_busy  out  1  high from the cycle after an accepted start until done.
ctrl_done  out  1  one-cycle completion pulse.
m_axi_arvalid  out  1  AR valid.
m_axi_arready  in  1  AR ready.
m_axi_araddr  out  C_ADDR_WIDTH  burst byte address.
m_axi_arlen  out  8  beats minus 1.
m_axi_rvalid  in  1  R valid (monitor only).
m_axi_rready  in  1  R ready, driven by the data consumer (monitor only).
m_axi_rlast  in  1  R last (monitor only).

Behaviour:
- Reset values: arvalid=0, araddr=0, arlen=0, ctrl_busy=0, ctrl_done=0, state IDLE, outstanding=0, remaining beats=0.
- Reset mid-operation abandons the transfer. In-flight bursts are forgotten; no done pulse is produced.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - ctrl_start with size>0: latch address and beats = size/BPB, go to ISSUE, busy=1 next cycle.
  - ctrl_start with size==0: ctrl_done=1 next cycle, stay IDLE, busy stays 0.
- ctrl_start outside IDLE is ignored.
- ISSUE:
  - Burst beats B = min(remaining, C_BURST_LEN), further limited by the 4 KB rule (see Optional Feature).
  - arvalid asserts when remaining>0 and outstanding<C_MAX_OUTSTANDING. araddr=current address, arlen=B-1.
  - While arvalid & !arready: araddr, arlen and arvalid are held stable. arvalid is never withdrawn, even if the outstanding count changes.
  - On the handshake: address += B*BPB, remaining -= B, outstanding += 1.
  - arvalid may stay high back-to-back, giving one burst per cycle when arready=1 and credit is available.
  - When remaining reaches 0 after a handshake: go to DRAIN, arvalid=0.
- Outstanding counter:
  - Decrements on rvalid & rready & rlast.
  - An AR handshake and an rlast beat in the same cycle leave it unchanged.
  - Never exceeds C_MAX_OUTSTANDING. Width is clog2(C_MAX_OUTSTANDING+1).
  - rlast with outstanding==0 is a protocol error: the counter saturates at 0.
- DRAIN: when outstanding==0 (after any decrement that cycle), assert ctrl_done for one cycle, clear busy and go to IDLE. The done and busy-clear are registered (same cycle).
- Latency:
  - First arvalid rises 1 cycle after the accepted start.
  - Done rises 1 cycle after the final rlast beat, provided all ARs have been issued.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH with no error.

Optional Feature:
Macro AXIM_RD_4K_SPLIT_EN.
- Defined: B is additionally limited to (4096 - (address mod 4096))/BPB, so no burst crosses a 4 KB boundary (AXI4-compliant for any aligned start address).
- Undefined: no boundary check. The caller guarantees that C_BURST_LEN*BPB ≤ 4096 and that the start address is aligned to C_BURST_LEN*BPB. This saves one subtractor and comparator.

Test Plan:
- Defaults, addr 0x0, size 8192, arready=1, rlast returned per burst → 2 ARs: (0x0, arlen 63) and (0x1000, arlen 63). ctrl_done 1 cycle after the 2nd rlast. busy high throughout.
- addr 0xF80, size 256, macro defined → ARs (0xF80, arlen 1) and (0x1000, arlen 1). Macro undefined → single AR (0xF80, arlen 3).
- C_MAX_OUTSTANDING=2, size 4 bursts, arready=1, no rlast → exactly 2 ARs, then arvalid=0. One rlast → 3rd AR the next cycle.
- arready held low 5 cycles on the first AR → araddr/arlen stable and arvalid high for all 5 cycles. Handshake on cycle 6. An rlast arriving in the same cycle as an AR handshake leaves outstanding unchanged.
- size 0 start → ctrl_done pulse next cycle, no arvalid, busy stays 0. ctrl_start while busy → ignored, AR sequence unchanged.
- rst asserted mid-ISSUE with 3 outstanding → next cycle arvalid=0, busy=0, no done. A new start then completes normally with a fresh outstanding count of 0.
